tfr_coalesce: RTL and testbench
===============================

Name: tfr_coalesce

Overview:
- Single-clock stage that sits directly upstream of the slow request/acknowledge clock-domain value-transfer block, in the source domain.
- The transfer block accepts one value per full round trip. Producers upstream emit strobes with no backpressure.
- This block absorbs that rate mismatch. It holds one word on an AXI-stream style output, coalesces later arrivals into a single pending slot, and tags each delivered word with the number of samples discarded for it.

Parameters:
- W, 32, data width.
- CW, 4, width of per-word drop count; saturating.
- KEEP_LATEST, 1, 1 = a new arrival overwrites the pending word; 0 = the pending word is kept and the arrival is discarded.

Ports:
- i_clk  input  1  clock.
- i_reset_n  input  1  reset.
- i_stb  input  1  new sample strobe; no backpressure.
- i_data  input  W  sample value, qualified by i_stb.
- o_valid  output  1  output word valid.
- i_ready  input  1  downstream accepts the word.
- o_data  output  W  output word.
- o_drops  output  CW  samples discarded in place of/after this word; saturates at all-ones.
- o_overflow  output  1  sticky; set whenever any sample is discarded.
- i_clr_overflow  input  1  clears o_overflow.
- o_total_drops  output  32  saturating count of all discarded samples since reset.

Interface rule (already decided): one clock, i_clk. Reset i_reset_n is asynchronous and active-low. All state is cleared on its falling edge; release is synchronous to i_clk.

Behaviour:
- Reset: o_valid=0, o_data=0, o_drops=0, o_overflow=0, o_total_drops=0, pend_full=0, pend_data=0, pend_drops=0.
- State:
  - Output slot: o_valid, o_data, o_drops.
  - Pending slot: pend_full, pend_data, pend_drops.
- Define out_free = !o_valid || i_ready.
- AXI rule: while o_valid && !i_ready, o_valid, o_data and o_drops are held stable.
- Each clock, with pend_full=0:
  - i_stb && out_free: output slot loads {i_data, 0}; o_valid=1. Latency is 1 cycle.
  - i_stb && !out_free: pending slot loads {i_data, 0}; pend_full=1.
  - !i_stb && out_free: o_valid=0.
- Each clock, with pend_full=1:
  - out_free: output slot loads {pend_data, pend_drops}; o_valid=1.
    - If i_stb, the pending slot reloads {i_data, 0} and stays full.
    - Otherwise pend_full=0.
  - !out_free && i_stb: one sample is discarded; pend_drops increments, saturating.
    - KEEP_LATEST=1: pend_data <= i_data.
    - KEEP_LATEST=0: pend_data is unchanged.
- Discard side effects: every discarded sample increments o_total_drops (saturating at 32'hFFFF_FFFF) and sets o_overflow.
- Simultaneous discard and i_clr_overflow: the set wins; o_overflow stays 1.
- Without a discard, i_clr_overflow clears o_overflow on the next edge.
- At most one sample is accepted per clock, so there are at most two words in flight. A sample is never lost without being counted.
- Reset mid-transfer: all words are discarded and the counts restart at 0. The downstream transfer block is reset together with this one.
- Arithmetic: all counters are unsigned and saturating; there is no wrap-around.

Decomposition:
- No shared package is needed.
- Parameters are local. The saturating increment is a local function used for both counters.
- Natural sub-module: none. The block is one always block per slot plus counters, about 150–200 lines including formal properties.
- Formal properties cover:
  - AXI output stability.
  - o_valid low out of reset.
  - pend_full implies o_valid.
  - Conservation: accepted samples = delivered + discarded + in-flight.

Test Plan:
- Single strobe, i_ready=1: i_stb with 0xA5 at cycle 0 -> o_valid=1, o_data=0xA5, o_drops=0 at cycle 1; o_valid=0 at cycle 2.
- Stall and pend: i_ready=0, strobes 1 then 2 -> o_data=1 held. Raise i_ready -> next word 2 with drops=0.
- Coalesce, KEEP_LATEST=1: i_ready=0, strobes 1,2,3,4,5 -> on release, words delivered are 1 then 5 with o_drops=3; o_total_drops=3; o_overflow=1.
- Coalesce, KEEP_LATEST=0: same stimulus -> words 1 then 2 with o_drops=3.
- Saturation, CW=4: 20 discards into the pending slot -> o_drops=15, o_total_drops=20.
- Clear versus set: i_clr_overflow in the same cycle as a discard -> o_overflow stays 1. i_clr_overflow alone next cycle -> o_overflow=0.
- Async reset: assert i_reset_n low mid-stall with both slots full -> o_valid=0 immediately. After release, the first strobe is delivered with drops=0 and the counters are 0.

Source files
------------

// File: rtl/tfr_coalesce.sv
// tfr_coalesce
//   Source-domain rate absorber placed in front of the request/acknowledge
//   value-transfer block. Upstream strobes arrive with no backpressure; this
//   block holds one word on an AXI-stream style output and coalesces later
//   arrivals into a single pending slot. Each delivered word carries a count
//   of the samples discarded in its place.
//
// Ports
//   i_clk           clock
//   i_reset_n       asynchronous active-low reset, synchronous release
//   i_stb, i_data   new sample strobe and value (no backpressure)
//   o_valid/i_ready output handshake
//   o_data          output word
//   o_drops         samples discarded in place of/after this word (saturating)
//   o_overflow      sticky discard flag, cleared by i_clr_overflow
//   i_clr_overflow  clears o_overflow (a discard in the same cycle wins)
//   o_total_drops   saturating count of all discarded samples since reset
module tfr_coalesce #(
  parameter int unsigned W           = 32,
  parameter int unsigned CW          = 4,
  parameter bit          KEEP_LATEST = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_stb,
  input  logic [W-1:0]  i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_drops,
  output logic          o_overflow,
  input  logic          i_clr_overflow,
  output logic [31:0]   o_total_drops
);

  localparam logic [31:0] CW_MAX  = 32'((33'd1 << CW) - 33'd1);
  localparam logic [31:0] TOT_MAX = '1;

  // Increment that sticks at max instead of wrapping; shared by both counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

  logic          pend_full;
  logic [W-1:0]  pend_data;
  logic [CW-1:0] pend_drops;

  logic out_free;
  logic discard;

  assign out_free = !o_valid || i_ready;
  // Only a full pending slot behind a stalled output can lose a sample.
  assign discard  = pend_full && !out_free && i_stb;

  // Output slot: the pending word always takes priority over a fresh strobe.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_drops <= '0;
    end else if (out_free) begin
      if (pend_full) begin
        o_valid <= 1'b1;
        o_data  <= pend_data;
        o_drops <= pend_drops;
      end else if (i_stb) begin
        o_valid <= 1'b1;
        o_data  <= i_data;
        o_drops <= '0;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

  // Pending slot.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pend_full  <= 1'b0;
      pend_data  <= '0;
      pend_drops <= '0;
    end else if (pend_full) begin
      if (out_free) begin
        if (i_stb) begin
          pend_data  <= i_data;
          pend_drops <= '0;
        end else begin
          pend_full  <= 1'b0;
        end
      end else if (i_stb) begin
        pend_drops <= CW'(sat_inc(32'(pend_drops), CW_MAX));
        if (KEEP_LATEST) pend_data <= i_data;
      end
    end else if (i_stb && !out_free) begin
      pend_full  <= 1'b1;
      pend_data  <= i_data;
      pend_drops <= '0;
    end
  end

  // Global discard accounting.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_overflow    <= 1'b0;
      o_total_drops <= '0;
    end else begin
      if (discard) begin
        o_overflow    <= 1'b1;
        o_total_drops <= sat_inc(o_total_drops, TOT_MAX);
      end else if (i_clr_overflow) begin
        o_overflow    <= 1'b0;
      end
    end
  end

`ifdef FORMAL
  logic [31:0] f_accepted, f_delivered, f_discarded;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      f_accepted  <= '0;
      f_delivered <= '0;
      f_discarded <= '0;
    end else begin
      if (i_stb)              f_accepted  <= f_accepted + 32'd1;
      if (o_valid && i_ready) f_delivered <= f_delivered + 32'd1;
      if (discard)            f_discarded <= f_discarded + 32'd1;
    end
  end

  a_axi_stable: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (o_valid && !i_ready) |=> (o_valid && $stable(o_data) && $stable(o_drops)));
  a_reset_valid: assert property (@(posedge i_clk)
    $rose(i_reset_n) |-> !o_valid);
  a_pend_implies_valid: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    pend_full |-> o_valid);
  a_conservation: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    f_accepted == f_delivered + f_discarded + 32'(o_valid) + 32'(pend_full));
`endif

endmodule

// File: tb/tb_tfr_coalesce.sv
module tb_tfr_coalesce;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stb;
  logic [W-1:0]  data;
  logic          ready;
  logic          clr;

  logic          v1, v0;
  logic [W-1:0]  d1, d0;
  logic [CW-1:0] dr1, dr0;
  logic          ov1, ov0;
  logic [31:0]   tot1, tot0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  tfr_coalesce #(.W(W), .CW(CW), .KEEP_LATEST(1'b1)) u_latest (
    .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb), .i_data(data),
    .o_valid(v1), .i_ready(ready), .o_data(d1), .o_drops(dr1),
    .o_overflow(ov1), .i_clr_overflow(clr), .o_total_drops(tot1)
  );

  tfr_coalesce #(.W(W), .CW(CW), .KEEP_LATEST(1'b0)) u_oldest (
    .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb), .i_data(data),
    .o_valid(v0), .i_ready(ready), .o_data(d0), .o_drops(dr0),
    .o_overflow(ov0), .i_clr_overflow(clr), .o_total_drops(tot0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string tag, input logic vx, input logic [31:0] dl,
                            input logic [31:0] dol, input logic [31:0] drx);
    chk({tag, "_valid1"}, 32'(v1), 32'(vx));
    chk({tag, "_valid0"}, 32'(v0), 32'(vx));
    chk({tag, "_data1"},  d1, dl);
    chk({tag, "_data0"},  d0, dol);
    chk({tag, "_drops1"}, 32'(dr1), drx);
    chk({tag, "_drops0"}, 32'(dr0), drx);
  endtask

  initial begin
    rst_n = 1'b0; stb = 1'b0; data = '0; ready = 1'b0; clr = 1'b0;
    #12;
    check_both("reset", 1'b0, 32'h0, 32'h0, 32'd0);
    chk("reset_ovf", 32'(ov1), 32'd0);
    chk("reset_tot", tot1, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Single strobe with ready high.
    ready = 1'b1; stb = 1'b1; data = 32'hA5;
    tick();
    check_both("single", 1'b1, 32'hA5, 32'hA5, 32'd0);
    stb = 1'b0;
    tick();
    chk("single_done", 32'(v1), 32'd0);

    // Stall and pend.
    ready = 1'b0; stb = 1'b1; data = 32'd1;
    tick();
    data = 32'd2;
    tick();
    check_both("stall_hold", 1'b1, 32'd1, 32'd1, 32'd0);
    stb = 1'b0;
    tick();
    check_both("stall_hold2", 1'b1, 32'd1, 32'd1, 32'd0);
    ready = 1'b1;
    tick();
    check_both("pend_out", 1'b1, 32'd2, 32'd2, 32'd0);
    tick();
    chk("pend_drain", 32'(v1), 32'd0);
    chk("pend_nodrop", tot1, 32'd0);
    chk("pend_noovf", 32'(ov1), 32'd0);

    // Coalesce: strobes 1..5 with output stalled.
    ready = 1'b0; stb = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      data = 32'(i);
      tick();
    end
    check_both("coal_hold", 1'b1, 32'd1, 32'd1, 32'd0);
    stb = 1'b0; ready = 1'b1;
    tick();
    check_both("coal_out", 1'b1, 32'd5, 32'd2, 32'd3);
    chk("coal_tot1", tot1, 32'd3);
    chk("coal_tot0", tot0, 32'd3);
    chk("coal_ovf1", 32'(ov1), 32'd1);
    chk("coal_ovf0", 32'(ov0), 32'd1);
    tick();
    chk("coal_drain", 32'(v0), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovf", 32'(ov1), 32'd0);
    chk("clr_keeptot", tot1, 32'd3);

    // Fresh counters for saturation.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    ready = 1'b0; stb = 1'b1; data = 32'h100;
    tick();
    data = 32'h101;
    tick();
    for (int i = 0; i < 20; i++) begin
      data = 32'h200 + 32'(i);
      clr = (i == 19);   // clear coincides with the last discard
      tick();
    end
    chk("sat_tot1", tot1, 32'd20);
    chk("sat_tot0", tot0, 32'd20);
    chk("clrset_ovf1", 32'(ov1), 32'd1);
    chk("clrset_ovf0", 32'(ov0), 32'd1);
    stb = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_alone_ovf1", 32'(ov1), 32'd0);
    chk("clr_alone_ovf0", 32'(ov0), 32'd0);
    check_both("sat_hold", 1'b1, 32'h100, 32'h100, 32'd0);
    ready = 1'b1;
    tick();
    check_both("sat_out", 1'b1, 32'h213, 32'h101, 32'd15);
    tick();

    // Async reset with both slots full.
    ready = 1'b0; stb = 1'b1; data = 32'd7;
    tick();
    data = 32'd8;
    tick();
    data = 32'd9;
    tick();
    stb = 1'b0;
    chk("pre_rst_tot", tot1, 32'd21);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid1", 32'(v1), 32'd0);
    chk("async_valid0", 32'(v0), 32'd0);
    chk("async_tot", tot1, 32'd0);
    chk("async_ovf", 32'(ov1), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    ready = 1'b1; stb = 1'b1; data = 32'h33;
    tick();
    stb = 1'b0;
    check_both("post_rst", 1'b1, 32'h33, 32'h33, 32'd0);
    chk("post_rst_tot", tot0, 32'd0);
    tick();
    chk("post_rst_drain", 32'(v1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
